// File: rtl/cn_driver.sv
// Excitation generator for a CN flip-flop: target bits are queued in a small
// FIFO and turned into c/n pulses. The optional q checker is enabled by CN_DRV_CHECK_EN.
module cn_driver #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tgt_valid,
    input  logic             tgt_bit,
    output logic             tgt_ready,
    input  logic             step,
    output logic             c,
    output logic             n,
    input  logic             q_fb,
    output logic             busy,
    output logic             err,
    output logic [CNT_W-1:0] chg_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        ERROR
    } state_t;

    state_t           state_q, state_d;
    logic [DEPTH-1:0] mem_q;
    logic [AW:0]      wrPtr_q, wrPtr_d;
    logic [AW:0]      rdPtr_q, rdPtr_d;
    logic             cn_q, cn_d;
    logic             modelQ_q, modelQ_d;
    logic [CNT_W-1:0] chgCnt_q, chgCnt_d;

    logic             empty;
    logic             full;
    logic             head;
    logic             inError;
    logic             pushEn;
    logic             popEn;
    logic             toggle;
    logic             lastEntry;
    logic             mismatch;
    logic             checkPending;

    // The extra pointer MSB separates a full FIFO from an empty one.
    assign empty     = (wrPtr_q == rdPtr_q);
    assign full      = (wrPtr_q[AW] != rdPtr_q[AW]) &&
                       (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
    assign head      = mem_q[rdPtr_q[AW-1:0]];
    assign inError   = (state_q == ERROR);
    assign tgt_ready = !full && !inError;
    assign pushEn    = tgt_valid && tgt_ready;
    assign popEn     = step && !empty && !inError;
    assign toggle    = head ^ modelQ_q;
    assign lastEntry = ((wrPtr_q - rdPtr_q) == PTR_ONE);

    assign c       = cn_q;
    assign n       = cn_q;
    assign chg_cnt = chgCnt_q;
    assign busy    = !empty || checkPending;

    always_comb begin
        wrPtr_d  = wrPtr_q;
        rdPtr_d  = rdPtr_q;
        cn_d     = 1'b0;
        modelQ_d = modelQ_q;
        chgCnt_d = chgCnt_q;

        if (pushEn) begin
            wrPtr_d = wrPtr_q + PTR_ONE;
        end

        if (popEn) begin
            rdPtr_d  = rdPtr_q + PTR_ONE;
            cn_d     = toggle;
            modelQ_d = head;
            if (toggle && (chgCnt_q != {CNT_W{1'b1}})) begin
                chgCnt_d = chgCnt_q + CNT_ONE;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (pushEn) begin
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                if (popEn && lastEntry && !pushEn) begin
                    state_d = IDLE;
                end
            end
            ERROR: begin
                state_d = ERROR;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (mismatch) begin
            state_d = ERROR;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            wrPtr_q  <= '0;
            rdPtr_q  <= '0;
            cn_q     <= 1'b0;
            modelQ_q <= 1'b0;
            chgCnt_q <= '0;
        end else begin
            state_q  <= state_d;
            wrPtr_q  <= wrPtr_d;
            rdPtr_q  <= rdPtr_d;
            cn_q     <= cn_d;
            modelQ_q <= modelQ_d;
            chgCnt_q <= chgCnt_d;
        end
    end

    // Storage needs no reset: an empty FIFO never exposes stale entries.
    always_ff @(posedge clk) begin
        if (pushEn) begin
            mem_q[wrPtr_q[AW-1:0]] <= tgt_bit;
        end
    end

`ifdef CN_DRV_CHECK_EN
    logic v1_q;
    logic exp1_q;
    logic v2_q;
    logic exp2_q;
    logic err_q;

    // Two stages: one for c/n to reach the flip-flop, one for q to settle.
    always_ff @(posedge clk) begin
        if (reset) begin
            v1_q   <= 1'b0;
            exp1_q <= 1'b0;
            v2_q   <= 1'b0;
            exp2_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            v1_q   <= popEn;
            exp1_q <= popEn ? head : exp1_q;
            v2_q   <= v1_q;
            exp2_q <= exp1_q;
            if (mismatch) begin
                err_q <= 1'b1;
            end
        end
    end

    assign mismatch     = v2_q && (q_fb != exp2_q);
    assign checkPending = v1_q || v2_q;
    assign err          = err_q;
`else
    logic unused_qfb;

    assign unused_qfb   = q_fb;
    assign mismatch     = 1'b0;
    assign checkPending = 1'b0;
    assign err          = 1'b0;
`endif

endmodule

// File: tb/tb_cn_driver.sv
// Randomized and directed bench for cn_driver against a queue-based model;
// a behavioural CN flip-flop closes the loop through q_fb.
module tb_cn_driver;

`ifdef CN_DRV_CHECK_EN
    localparam bit CHECK = 1'b1;
`else
    localparam bit CHECK = 1'b0;
`endif
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       tgtValid;
    logic       tgtBit;
    logic       step;
    logic       qFb;
    logic       ffQ;
    logic       forceQ;
    logic       forceVal;

    logic       readyMain, cMain, nMain, busyMain, errMain;
    logic [7:0] cntMain;
    logic       readySat, cSat, nSat, busySat, errSat;
    logic [1:0] cntSat;

    int checkCount = 0;
    int failCount  = 0;

    bit modelQueue[$];
    bit modelQ;
    bit cnExp;
    bit errExp;
    int toggles;
    int edgeNum;
    bit popB[int];

    always #5 clk = ~clk;

    cn_driver #(.DEPTH(DEPTH), .CNT_W(8)) dutMain (
        .clk(clk), .reset(reset), .tgt_valid(tgtValid), .tgt_bit(tgtBit),
        .tgt_ready(readyMain), .step(step), .c(cMain), .n(nMain), .q_fb(qFb),
        .busy(busyMain), .err(errMain), .chg_cnt(cntMain)
    );

    cn_driver #(.DEPTH(DEPTH), .CNT_W(2)) dutSat (
        .clk(clk), .reset(reset), .tgt_valid(tgtValid), .tgt_bit(tgtBit),
        .tgt_ready(readySat), .step(step), .c(cSat), .n(nSat), .q_fb(qFb),
        .busy(busySat), .err(errSat), .chg_cnt(cntSat)
    );

    // Downstream CN flip-flop: q=0 -> c&n, q=1 -> ~n.
    always @(posedge clk) begin
        if (reset) ffQ <= 1'b0;
        else       ffQ <= ffQ ? ~nMain : (cMain & nMain);
    end

    assign qFb = forceQ ? forceVal : ffQ;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic bit poppedAt(input int e);
        return popB.exists(e);
    endfunction

    // Advance the model across the upcoming clock edge.
    task automatic modelEdge(input bit rst, input bit v, input bit b, input bit s);
        bit ready, push, pop, head;
        if (rst) begin
            modelQueue.delete();
            popB.delete();
            modelQ  = 1'b0;
            cnExp   = 1'b0;
            errExp  = 1'b0;
            toggles = 0;
            return;
        end
        ready = (modelQueue.size() < DEPTH) && !errExp;
        push  = v && ready;
        pop   = s && (modelQueue.size() > 0) && !errExp;
        cnExp = 1'b0;
        if (CHECK && poppedAt(edgeNum - 2) && (qFb != popB[edgeNum - 2])) begin
            errExp = 1'b1;
        end
        if (pop) begin
            head  = modelQueue.pop_front();
            cnExp = head ^ modelQ;
            if (head != modelQ) toggles++;
            modelQ = head;
            popB[edgeNum] = head;
        end
        if (push) modelQueue.push_back(b);
    endtask

    task automatic applyStimulus(input bit rst, input bit v, input bit b, input bit s);
        bit busyExp;
        @(negedge clk);
        reset    = rst;
        tgtValid = v;
        tgtBit   = b;
        step     = s;
        modelEdge(rst, v, b, s);
        @(posedge clk);
        edgeNum++;
        #1;
        busyExp = (modelQueue.size() > 0) ||
                  (CHECK && (poppedAt(edgeNum - 1) || poppedAt(edgeNum - 2)));
        checkOutput("c", cMain, cnExp);
        checkOutput("n", nMain, cnExp);
        checkOutput("csat", cSat, cnExp);
        checkOutput("ready", readyMain, (modelQueue.size() < DEPTH) && !errExp);
        checkOutput("busy", busyMain, busyExp);
        checkOutput("err", errMain, errExp);
        checkOutput("cnt8", cntMain, (toggles > 255) ? 255 : toggles);
        checkOutput("cnt2", cntSat, (toggles > 3) ? 3 : toggles);
    endtask

    initial begin
        reset    = 1'b1;
        tgtValid = 1'b0;
        tgtBit   = 1'b0;
        step     = 1'b0;
        forceQ   = 1'b0;
        forceVal = 1'b0;
        edgeNum  = 0;
        repeat (2) @(posedge clk);

        $display("[TB] reset state");
        applyStimulus(1, 0, 0, 0);
        checkOutput("rst_busy", busyMain, 0);
        checkOutput("rst_ready", readyMain, 1);

        $display("[TB] feed-through 1,0,0,1");
        applyStimulus(0, 1, 1, 1);
        applyStimulus(0, 1, 0, 1);
        checkOutput("ft_c0", cMain, 1);
        applyStimulus(0, 1, 0, 1);
        checkOutput("ft_c1", cMain, 1);
        applyStimulus(0, 1, 1, 1);
        checkOutput("ft_c2", cMain, 0);
        applyStimulus(0, 0, 0, 1);
        checkOutput("ft_c3", cMain, 1);
        checkOutput("ft_cnt", cntMain, 3);
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 0, 1);
        checkOutput("ft_q", ffQ, 1);
        checkOutput("ft_err", errMain, 0);

        $display("[TB] full FIFO");
        applyStimulus(1, 0, 0, 0);
        for (int i = 0; i < 6; i++) applyStimulus(0, 1, i[0], 0);
        checkOutput("full_ready", readyMain, 0);
        applyStimulus(0, 0, 0, 1);
        checkOutput("full_ready_back", readyMain, 1);
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 1);

        $display("[TB] counter saturation");
        applyStimulus(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) applyStimulus(0, 1, ~i[0], 1);
        applyStimulus(0, 0, 0, 1);
        checkOutput("sat_cnt2", cntSat, 3);
        checkOutput("sat_cnt8", cntMain, 5);
        applyStimulus(0, 0, 0, 1);

        $display("[TB] reset mid-stream");
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 1, 1, 1);
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 1, 0);
        applyStimulus(1, 0, 0, 0);
        checkOutput("mid_busy", busyMain, 0);
        checkOutput("mid_c", cMain, 0);
        checkOutput("mid_cnt", cntMain, 0);
        applyStimulus(0, 1, 0, 1);
        applyStimulus(0, 0, 0, 1);
        checkOutput("mid_c_after", cMain, 0);
        applyStimulus(0, 0, 0, 1);

`ifdef CN_DRV_CHECK_EN
        $display("[TB] forced mismatch");
        applyStimulus(1, 0, 0, 0);
        forceQ   = 1'b1;
        forceVal = 1'b0;
        applyStimulus(0, 1, 1, 1);
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 0, 1);
        checkOutput("mm_err_early", errMain, 0);
        applyStimulus(0, 1, 0, 1);
        checkOutput("mm_err", errMain, 1);
        checkOutput("mm_ready", readyMain, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 1, 1);
        checkOutput("mm_c", cMain, 0);
        checkOutput("mm_sticky", errMain, 1);
        forceQ = 1'b0;
        applyStimulus(1, 0, 0, 0);
        checkOutput("mm_clear", errMain, 0);
`endif

        $display("[TB] random traffic");
        applyStimulus(1, 0, 0, 0);
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 7),
                          1'($urandom), ($urandom_range(0, 9) < 6));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
